// File: rtl/score_display_pkg.sv
// Shared constants, FSM state type and helper function for the score display driver.
package score_display_pkg;

  // Active-low segment patterns, bit 0 = segment a .. bit 6 = segment g.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StUpdate
  } state_e;

  // 10^n, evaluated at elaboration time to derive the display limit.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder. Non-decimal codes blank.
module hex_to_seg
  import score_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Digit lookup; anything above 9 is shown as blank.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Sequential binary-to-BCD (double-dabble) seven-segment display driver.
// One bit is converted per clock; the display registers update atomically when the
// conversion completes. A load arriving while busy is queued (latest value wins).
// Optional feature macro: SCORE_DISPLAY_BLANK_EN enables leading-zero blanking.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned VALUE_W = 14
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned     BcdW = 4 * DIGITS;
  localparam int unsigned     CntW = $clog2(VALUE_W + 1);
  localparam longint unsigned MAX  = pow10(DIGITS) - 64'd1;

`ifdef SCORE_DISPLAY_BLANK_EN
  localparam logic [6:0] SegLead = SEG_BLANK;
`else
  localparam logic [6:0] SegLead = SEG_ZERO;
`endif

  // Reset display: units digit shows 0, upper digits follow the blanking setting.
  function automatic logic [7*DIGITS-1:0] hex_reset_value();
    logic [7*DIGITS-1:0] v;
    v = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      v[7*d+:7] = (d == 0) ? SEG_ZERO : SegLead;
    end
    return v;
  endfunction

  localparam logic [7*DIGITS-1:0] HexRst = hex_reset_value();

  // State and datapath registers
  state_e               r_state;
  state_e               w_state_d;
  logic [VALUE_W-1:0]   r_bin;
  logic [BcdW-1:0]      r_bcd;
  logic [CntW-1:0]      r_cnt;
  logic                 r_ovf_cap;
  logic                 r_pend;
  logic [VALUE_W-1:0]   r_pend_val;
  logic                 r_done;
  logic                 r_overflow;
  logic [7*DIGITS-1:0]  r_hex;

  // Next-state / control wires
  logic                 w_start;
  logic [VALUE_W-1:0]   w_start_val;
  logic                 w_start_ovf;
  logic                 w_pend_d;
  logic [VALUE_W-1:0]   w_pend_val_d;
  logic [BcdW-1:0]      w_bcd_adj;
  logic [BcdW-1:0]      w_bcd_shift;
  logic [7*DIGITS-1:0]  w_seg;
  logic [DIGITS-1:0]    w_blank;
  logic [7*DIGITS-1:0]  w_hex_d;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state, conversion start selection and pending-request bookkeeping
  always_comb begin
    w_state_d    = r_state;
    w_start      = 1'b0;
    w_start_val  = value;
    w_pend_d     = r_pend;
    w_pend_val_d = r_pend_val;
    unique case (r_state)
      StIdle: begin
        if (load) begin
          w_start   = 1'b1;
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (load) begin
          w_pend_d     = 1'b1;
          w_pend_val_d = value;
        end
        if (r_cnt == CntW'(1)) begin
          w_state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (r_pend) begin
          // Restart from the queued value; a load this cycle becomes the new queue entry.
          w_start      = 1'b1;
          w_start_val  = r_pend_val;
          w_state_d    = StShift;
          w_pend_d     = load;
          if (load) begin
            w_pend_val_d = value;
          end
        end else if (load) begin
          // Queued and consumed in the same cycle.
          w_start   = 1'b1;
          w_state_d = StShift;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_start_ovf = (64'(w_start_val) > MAX);

  // Add-3 correction on every nibble >= 5 ahead of the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d+:4] >= 4'd5) begin
        w_bcd_adj[4*d+:4] = r_bcd[4*d+:4] + 4'd3;
      end
    end
  end

  assign w_bcd_shift = {w_bcd_adj[BcdW-2:0], r_bin[VALUE_W-1]};

  // Conversion datapath: capture on start, shift one bit per SHIFT cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
    end else if (w_start) begin
      r_bin     <= w_start_val;
      r_bcd     <= '0;
      r_cnt     <= CntW'(VALUE_W);
      r_ovf_cap <= w_start_ovf;
    end else if (r_state == StShift) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_shift;
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  // Pending request register; a later load overwrites the stored value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else begin
      r_pend     <= w_pend_d;
      r_pend_val <= w_pend_val_d;
    end
  end

  // Per-digit segment decoders on the finished BCD accumulator
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    hex_to_seg u_hex_to_seg (
      .i_digit (r_bcd[4*g+:4]),
      .o_seg   (w_seg[7*g+:7])
    );
  end

`ifdef SCORE_DISPLAY_BLANK_EN
  logic w_seen_nz;

  // Blank zero digits above the most significant non-zero digit; units never blanks
  always_comb begin
    w_blank   = '0;
    w_seen_nz = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (r_bcd[4*d+:4] != 4'd0) begin
        w_seen_nz = 1'b1;
      end
      w_blank[d] = ~w_seen_nz;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Display image: dashes on overflow, otherwise decoded digits with blanking mask
  always_comb begin
    w_hex_d = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_ovf_cap) begin
        w_hex_d[7*d+:7] = SEG_DASH;
      end else if (w_blank[d]) begin
        w_hex_d[7*d+:7] = SEG_BLANK;
      end else begin
        w_hex_d[7*d+:7] = w_seg[7*d+:7];
      end
    end
  end

  // Output registers: only written in UPDATE, so partial results never reach the pins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hex      <= HexRst;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == StUpdate);
      if (r_state == StUpdate) begin
        r_hex      <= w_hex_d;
        r_overflow <= r_ovf_cap;
      end
    end
  end

  assign busy     = (r_state != StIdle);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign hex      = r_hex;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (DIGITS=4, VALUE_W=14). Expected displays are
// pushed to a scoreboard queue when a load is driven and compared on each done pulse.
module tb_score_display;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned VALUE_W = 14;
  localparam int unsigned MAXV    = 9999;
  localparam int unsigned LAT     = VALUE_W + 1;
`ifdef SCORE_DISPLAY_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [7*DIGITS-1:0] hex;
    logic                ovf;
    int unsigned         val;
  } exp_t;

  logic                 clk;
  logic                 resetn;
  logic [VALUE_W-1:0]   value;
  logic                 load;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [7*DIGITS-1:0]  hex;

  int   vectors;
  int   miscompares;
  int   cyc;
  int   load_cyc;
  exp_t sb[$];
  int   done_cycles[$];

  score_display #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg7(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] model_hex(input int unsigned v);
    logic [7*DIGITS-1:0] h;
    int unsigned p;
    h = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v > MAXV)                   h[7*i+:7] = 7'b0111111;
      else if (BLANK && i > 0 && v < p) h[7*i+:7] = 7'b1111111;
      else                            h[7*i+:7] = seg7((v / p) % 10);
      p = p * 10;
    end
    return h;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected display.
  always @(negedge clk) begin
    if (resetn && done) begin
      exp_t e;
      done_cycles.push_back(cyc);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done with hex=%h ovf=%b, required no done", hex,
                 overflow);
      end else begin
        e = sb.pop_front();
        if (hex !== e.hex || overflow !== e.ovf) begin
          miscompares++;
          $display("FAIL display_%0d: got hex=%h ovf=%b, required hex=%h ovf=%b", e.val, hex,
                   overflow, e.hex, e.ovf);
        end
      end
    end
  end

  task automatic push_exp(input int unsigned v);
    exp_t e;
    e.hex = model_hex(v);
    e.ovf = (v > MAXV);
    e.val = v;
    sb.push_back(e);
  endtask

  // Caller is at a negedge; load is accepted at the following posedge.
  task automatic apply_load(input int unsigned v, input bit expect_display);
    value = VALUE_W'(v);
    load  = 1'b1;
    if (expect_display) push_exp(v);
    @(negedge clk);
    load     = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic wait_dones(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cycles.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7*DIGITS-1:0] rst_hex;
    rst_hex = BLANK ? {7'h7F, 7'h7F, 7'h7F, 7'b1000000} : {4{7'b1000000}};
    resetn = 1'b0;
    load   = 1'b0;
    value  = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (hex !== rst_hex) begin
      miscompares++;
      $display("FAIL reset_hex: got %h, required %h", hex, rst_hex);
    end
    vectors++;
    if ({busy, done, overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/done/ovf=%b, required 000", {busy, done, overflow});
    end
  endtask

  task automatic test_basic();
    int n0;
    bit ok;
    logic [7*DIGITS-1:0] held;
    n0 = done_cycles.size();
    apply_load(1234, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_load: got %b, required 1", busy);
    end
    wait_dones(n0 + 1, 40, ok);
    vectors++;
    if (!ok || done_cycles[n0] - load_cyc != LAT) begin
      miscompares++;
      $display("FAIL latency_1234: got ok=%b cycles=%0d, required %0d", ok,
               ok ? done_cycles[n0] - load_cyc : -1, LAT);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_fall: got %b, required 0", busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: got %b, required 0", done);
    end
    held = model_hex(1234);
    repeat (20) @(negedge clk);
    vectors++;
    if (hex !== held || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got %h/%b, required %h/0", hex, overflow, held);
    end
  endtask

  task automatic test_overflow();
    int unsigned vals[4] = '{10000, 7, 9999, 16383};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      int n0;
      n0 = done_cycles.size();
      apply_load(vals[i], 1'b1);
      wait_dones(n0 + 1, 40, ok);
      vectors++;
      if (!ok || overflow !== (vals[i] > MAXV)) begin
        miscompares++;
        $display("FAIL overflow_%0d: got ok=%b ovf=%b, required ovf=%b", vals[i], ok, overflow,
                 vals[i] > MAXV);
      end
    end
  endtask

  task automatic test_queue();
    int n0;
    int t0;
    bit ok;
    n0 = done_cycles.size();
    apply_load(42, 1'b1);
    t0 = load_cyc;
    repeat (2) @(negedge clk);
    apply_load(99, 1'b0);
    @(negedge clk);
    apply_load(100, 1'b1);
    wait_dones(n0 + 2, 60, ok);
    vectors++;
    if (!ok || done_cycles[n0] - t0 != LAT || done_cycles[n0+1] - done_cycles[n0] != LAT) begin
      miscompares++;
      $display("FAIL queue_timing: got ok=%b first=%0d gap=%0d, required %0d/%0d", ok,
               ok ? done_cycles[n0] - t0 : -1, ok ? done_cycles[n0+1] - done_cycles[n0] : -1,
               LAT, LAT);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (done_cycles.size() != n0 + 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL queue_extra: got dones=%0d busy=%b, required 2 / 0",
               done_cycles.size() - n0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    bit ok;
    logic [7*DIGITS-1:0] rst_hex;
    rst_hex = BLANK ? {7'h7F, 7'h7F, 7'h7F, 7'b1000000} : {4{7'b1000000}};
    // Leave the display in overflow first so the reset visibly changes it.
    n0 = done_cycles.size();
    apply_load(10000, 1'b1);
    wait_dones(n0 + 1, 40, ok);
    @(negedge clk);
    n0 = done_cycles.size();
    apply_load(9999, 1'b0);
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    #1;
    vectors++;
    if (hex !== rst_hex || {busy, done, overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid: got hex=%h flags=%b, required hex=%h flags=000", hex,
               {busy, done, overflow}, rst_hex);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (done_cycles.size() != n0 || hex !== rst_hex) begin
      miscompares++;
      $display("FAIL reset_abort: got dones=%0d hex=%h, required 0 / %h", done_cycles.size() - n0,
               hex, rst_hex);
    end
  endtask

  task automatic test_zero_repeat();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      int n0;
      n0 = done_cycles.size();
      apply_load(0, 1'b1);
      wait_dones(n0 + 1, 40, ok);
      vectors++;
      if (!ok || hex[6:0] !== 7'b1000000 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_%0d: got ok=%b units=%b busy=%b, required 1000000 / 0", i, ok,
                 hex[6:0], busy);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 6; i++) begin
      int n0;
      n0 = done_cycles.size();
      apply_load($urandom_range(0, 16383), 1'b1);
      wait_dones(n0 + 1, 40, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL random_%0d_timeout: got no done, required done", i);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    load_cyc    = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_queue();
    test_reset_mid();
    test_zero_repeat();
    test_random();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
